// File: rtl/xoodyak_seq_pkg.sv
// xoodyak_seq_pkg: shared opmodes, sequencer states and default widths for xoodyak_seq_ctrl.
package xoodyak_seq_pkg;

    localparam int TEXT_W_DEF = 192;
    localparam int KEY_W_DEF  = 128;
    localparam int AD_W_DEF   = 352;
    localparam int CNT_W_DEF  = 6;

    typedef enum logic [3:0] {
        OP_IDLE     = 4'd0,
        OP_INIT     = 4'd1,
        OP_NONCE    = 4'd2,
        OP_ASSOC    = 4'd3,
        OP_CRYPT    = 4'd4,
        OP_DECRYPT  = 4'd5,
        OP_SQUEEZE  = 4'd6,
        OP_CONT_BIT = 4'd8
    } opmode_t;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_NONCE, S_ASSOC, S_GETBLK, S_CRYPT, S_PUTBLK, S_SQZ, S_PUTTAG
    } seq_state_t;

    function automatic logic is_cmd(input seq_state_t s);
        return s inside {S_INIT, S_NONCE, S_ASSOC, S_CRYPT, S_SQZ};
    endfunction

endpackage

// File: rtl/xoodyak_cmd_issue.sv
// xoodyak_cmd_issue: one-cycle start strobe on entry to a command state, then wait for finished.
module xoodyak_cmd_issue (
    input  logic eph1_i,
    input  logic reset_i,
    input  logic active_i,
    input  logic finished_i,
    output logic start_o,
    output logic done_o
);

    logic issued_q, issued_d;

    // a finished pulse coincident with start sees issued_q=0 and is dropped
    always_comb begin
        start_o  = active_i & ~issued_q;
        done_o   = active_i & issued_q & finished_i;
        issued_d = active_i & ~done_o;
    end

    always_ff @(posedge eph1_i) begin
        if (!reset_i) issued_q <= 1'b0;
        else          issued_q <= issued_d;
    end

endmodule

// File: rtl/xoodyak_seq_ctrl.sv
// xoodyak_seq_ctrl: AEAD job sequencer driving the xoodyak_build opmode/start interface.
// Optional decrypt tag check under `define XOODYAK_SEQ_VERIFY_EN.
module xoodyak_seq_ctrl
    import xoodyak_seq_pkg::*;
#(
    parameter int TEXT_W = TEXT_W_DEF,
    parameter int KEY_W  = KEY_W_DEF,
    parameter int AD_W   = AD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              eph1_i,
    input  logic              reset_i,
    input  logic              job_valid_i,
    output logic              job_ready_o,
    input  logic              job_dec_i,
    input  logic [CNT_W-1:0]  job_nblk_i,
    input  logic [KEY_W-1:0]  job_key_i,
    input  logic [KEY_W-1:0]  job_nonce_i,
    input  logic [AD_W-1:0]   job_ad_i,
    input  logic              blk_in_valid_i,
    output logic              blk_in_ready_o,
    input  logic [TEXT_W-1:0] blk_in_i,
    output logic              blk_out_valid_o,
    input  logic              blk_out_ready_i,
    output logic [TEXT_W-1:0] blk_out_o,
    output logic              tag_valid_o,
    input  logic              tag_ready_i,
    output logic [KEY_W-1:0]  tag_o,
    output logic              core_start_o,
    output logic [3:0]        core_opmode_o,
    output logic [TEXT_W-1:0] core_textin_o,
    output logic [KEY_W-1:0]  core_key_o,
    output logic [KEY_W-1:0]  core_nonce_o,
    output logic [AD_W-1:0]   core_ad_o,
    input  logic [TEXT_W-1:0] core_textout_i,
    input  logic              core_finished_i,
`ifdef XOODYAK_SEQ_VERIFY_EN
    input  logic [KEY_W-1:0]  job_tag_i,
    output logic              tag_ok_o,
`endif
    output logic              busy_o
);

    seq_state_t        state_q, state_d;
    logic              dec_q;
    logic [CNT_W-1:0]  rem_q;
    logic [KEY_W-1:0]  key_q, nonce_q, tag_q;
    logic [AD_W-1:0]   ad_q;
    logic [TEXT_W-1:0] textin_q, blkout_q;
    logic              done, accept, in_hs, rem_nz, last_blk;
`ifdef XOODYAK_SEQ_VERIFY_EN
    logic [KEY_W-1:0]  jtag_q;
`endif

    xoodyak_cmd_issue u_issue (
        .eph1_i     (eph1_i),
        .reset_i    (reset_i),
        .active_i   (is_cmd(state_q)),
        .finished_i (core_finished_i),
        .start_o    (core_start_o),
        .done_o     (done)
    );

    always_comb begin
        accept   = (state_q == S_IDLE) & job_valid_i;
        in_hs    = (state_q == S_GETBLK) & blk_in_valid_i;
        rem_nz   = |rem_q;
        last_blk = rem_q <= CNT_W'(1);
    end

    // continue bit marks every crypt block except the last one of the job
    assign core_opmode_o = state_q == S_INIT  ? 4'(OP_INIT)  :
                           state_q == S_NONCE ? 4'(OP_NONCE) :
                           state_q == S_ASSOC ? 4'(OP_ASSOC) :
                           state_q == S_CRYPT ? ((dec_q ? 4'(OP_DECRYPT) : 4'(OP_CRYPT)) |
                                                 (last_blk ? 4'(OP_IDLE) : 4'(OP_CONT_BIT))) :
                           state_q == S_SQZ   ? 4'(OP_SQUEEZE) : 4'(OP_IDLE);

    assign job_ready_o     = state_q == S_IDLE;
    assign busy_o          = state_q != S_IDLE;
    assign blk_in_ready_o  = state_q == S_GETBLK;
    assign blk_out_valid_o = state_q == S_PUTBLK;
    assign tag_valid_o     = state_q == S_PUTTAG;
    assign blk_out_o       = blkout_q;
    assign tag_o           = tag_q;
    assign core_textin_o   = textin_q;
    assign core_key_o      = key_q;
    assign core_nonce_o    = nonce_q;
    assign core_ad_o       = ad_q;
`ifdef XOODYAK_SEQ_VERIFY_EN
    assign tag_ok_o        = ~dec_q | (tag_q == jtag_q);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (job_valid_i)     state_d = S_INIT;
            S_INIT:   if (done)            state_d = S_NONCE;
            S_NONCE:  if (done)            state_d = S_ASSOC;
            S_ASSOC:  if (done)            state_d = rem_nz ? S_GETBLK : S_SQZ;
            S_GETBLK: if (blk_in_valid_i)  state_d = S_CRYPT;
            S_CRYPT:  if (done)            state_d = S_PUTBLK;
            S_PUTBLK: if (blk_out_ready_i) state_d = rem_nz ? S_GETBLK : S_SQZ;
            S_SQZ:    if (done)            state_d = S_PUTTAG;
            S_PUTTAG: if (tag_ready_i)     state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge eph1_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            dec_q    <= 1'b0;
            rem_q    <= '0;
            key_q    <= '0;
            nonce_q  <= '0;
            ad_q     <= '0;
            textin_q <= '0;
            blkout_q <= '0;
            tag_q    <= '0;
`ifdef XOODYAK_SEQ_VERIFY_EN
            jtag_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                dec_q   <= job_dec_i;
                rem_q   <= job_nblk_i;
                key_q   <= job_key_i;
                nonce_q <= job_nonce_i;
                ad_q    <= job_ad_i;
`ifdef XOODYAK_SEQ_VERIFY_EN
                jtag_q  <= job_tag_i;
`endif
            end
            if (in_hs) textin_q <= blk_in_i;
            if (done && state_q == S_CRYPT) begin
                blkout_q <= core_textout_i;
                rem_q    <= rem_q - CNT_W'(1);
            end
            if (done && state_q == S_SQZ) tag_q <= core_textout_i[KEY_W-1:0];
        end
    end

endmodule

// File: tb/tb_xoodyak_seq_ctrl.sv
// tb_xoodyak_seq_ctrl: scoreboard bench with a toy reversible core model behind the sequencer.
module tb_xoodyak_seq_ctrl;

    localparam int TW = 192;
    localparam int KW = 128;
    localparam int AW = 352;
    localparam int CW = 6;
    localparam logic [TW-1:0] PC = 192'h9e3779b97f4a7c15f39cc0605cedc8341082276bf3a27251;

    logic          clk = 1'b0;
    logic          reset_i, job_valid_i, job_ready_o, job_dec_i;
    logic [CW-1:0] job_nblk_i;
    logic [KW-1:0] job_key_i, job_nonce_i, tag_o, core_key_o, core_nonce_o;
    logic [AW-1:0] job_ad_i, core_ad_o;
    logic          blk_in_valid_i, blk_in_ready_o, blk_out_valid_o, blk_out_ready_i;
    logic [TW-1:0] blk_in_i, blk_out_o, core_textin_o, core_textout_i;
    logic          tag_valid_o, tag_ready_i, core_start_o, core_finished_i, busy_o;
    logic [3:0]    core_opmode_o;
`ifdef XOODYAK_SEQ_VERIFY_EN
    logic [KW-1:0] job_tag_i;
    logic          tag_ok_o;
`endif

    always #5 clk = ~clk;

    xoodyak_seq_ctrl dut (
        .eph1_i(clk), .reset_i(reset_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_dec_i(job_dec_i),
        .job_nblk_i(job_nblk_i), .job_key_i(job_key_i), .job_nonce_i(job_nonce_i), .job_ad_i(job_ad_i),
        .blk_in_valid_i(blk_in_valid_i), .blk_in_ready_o(blk_in_ready_o), .blk_in_i(blk_in_i),
        .blk_out_valid_o(blk_out_valid_o), .blk_out_ready_i(blk_out_ready_i), .blk_out_o(blk_out_o),
        .tag_valid_o(tag_valid_o), .tag_ready_i(tag_ready_i), .tag_o(tag_o),
        .core_start_o(core_start_o), .core_opmode_o(core_opmode_o), .core_textin_o(core_textin_o),
        .core_key_o(core_key_o), .core_nonce_o(core_nonce_o), .core_ad_o(core_ad_o),
        .core_textout_i(core_textout_i), .core_finished_i(core_finished_i),
`ifdef XOODYAK_SEQ_VERIFY_EN
        .job_tag_i(job_tag_i), .tag_ok_o(tag_ok_o),
`endif
        .busy_o(busy_o)
    );

    int nchk = 0, nerr = 0;
    int nstart = 0, nrdy = 0, spur_req = 0;
    bit abort = 0;
    logic [3:0]    exp_op[$];
    logic [TW-1:0] exp_blk[$];
    logic [KW-1:0] exp_tag[$];
    logic [TW-1:0] in_arr[8], out_arr[8], pt_arr[8];
    logic [KW-1:0] tag_out, tag_enc, K, N;
    logic [AW-1:0] A;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] perm(input logic [TW-1:0] x);
        return {x[178:0], x[191:179]} ^ (x >> 7) ^ PC;
    endfunction

    function automatic logic [TW-1:0] ad_fold(input logic [AW-1:0] a);
        return a[191:0] ^ {32'h0, a[351:192]};
    endfunction

    function automatic logic sig(input int s);
        case (s)
            0: return job_ready_o;
            1: return blk_in_ready_o;
            2: return blk_out_valid_o;
            3: return tag_valid_o;
            4: return core_start_o;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_hi(input string tag, input int s);
        int k = 0;
        while (!sig(s) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, TW'(sig(s)), 1);
    endtask

    always @(negedge clk) begin
        if (core_start_o) nstart++;
        if (blk_in_ready_o) nrdy++;
    end

    // toy core: absorbs key/nonce/ad, crypt xors a keystream and absorbs the plaintext
    logic [TW-1:0] c_st, c_tin, c_tout;
    logic [3:0]    c_op;
    int            c_lat, c_spur_done;
    bit            c_again;
    initial begin
        c_st = '0; c_spur_done = 0; c_again = 0;
        core_finished_i = 1'b0;
        core_textout_i = '0;
        forever begin
            if (!c_again) @(negedge clk);
            c_again = 0;
            if (core_start_o) begin
                c_op = core_opmode_o;
                c_tin = core_textin_o;
                if (exp_op.size() == 0) check("opq_empty", 0, 1);
                else check("opmode", TW'(c_op), TW'(exp_op.pop_front()));
                case (c_op[2:0])
                    3'd1: begin c_st = perm({64'h0, core_key_o}); c_tout = c_st; end
                    3'd2: begin c_st = perm(c_st ^ {64'h0, core_nonce_o}); c_tout = c_st; end
                    3'd3: begin c_st = perm(c_st ^ ad_fold(core_ad_o)); c_tout = c_st; end
                    3'd4, 3'd5: begin
                        c_tout = c_tin ^ perm(c_st ^ TW'(1));
                        c_st = perm(c_st ^ (c_op[0] ? c_tout : c_tin)) ^ TW'(c_op[3]);
                    end
                    3'd6: c_tout = perm(c_st ^ TW'(6));
                    default: c_tout = '0;
                endcase
                c_lat = $urandom_range(1, 3);
                repeat (c_lat) @(negedge clk);
                if (!abort) check("op_hold", TW'(core_opmode_o), TW'(c_op));
                core_finished_i = 1'b1;
                core_textout_i = c_tout;
                @(negedge clk);
                core_finished_i = 1'b0;
                core_textout_i = ~c_tout;
                c_again = 1;
            end else if (spur_req != c_spur_done) begin
                core_finished_i = 1'b1;
                @(negedge clk);
                core_finished_i = 1'b0;
                c_spur_done++;
                c_again = 1;
            end
        end
    end

    task automatic model(input logic dec, input int nblk, input logic [KW-1:0] k, n, input logic [AW-1:0] a);
        logic [TW-1:0] st, o, t;
        logic cont;
        st = perm({64'h0, k});
        st = perm(st ^ {64'h0, n});
        st = perm(st ^ ad_fold(a));
        exp_op.push_back(4'd1); exp_op.push_back(4'd2); exp_op.push_back(4'd3);
        for (int i = 0; i < nblk; i++) begin
            cont = i < nblk - 1;
            exp_op.push_back({cont, dec ? 3'd5 : 3'd4});
            o = in_arr[i] ^ perm(st ^ TW'(1));
            exp_blk.push_back(o);
            st = perm(st ^ (dec ? o : in_arr[i])) ^ TW'(cont);
        end
        exp_op.push_back(4'd6);
        t = perm(st ^ TW'(6));
        exp_tag.push_back(t[KW-1:0]);
    endtask

    task automatic accept_job(input logic dec, input int nblk, input logic [KW-1:0] k, n,
                              input logic [AW-1:0] a, input logic [KW-1:0] jt);
        wait_hi("job_ready", 0);
        job_valid_i = 1'b1; job_dec_i = dec; job_nblk_i = CW'(nblk);
        job_key_i = k; job_nonce_i = n; job_ad_i = a;
`ifdef XOODYAK_SEQ_VERIFY_EN
        job_tag_i = jt;
`endif
        @(negedge clk);
        job_valid_i = 1'b0; job_dec_i = ~dec; job_key_i = ~k; job_nonce_i = ~n; job_ad_i = ~a;
        job_nblk_i = CW'(nblk + 5);
`ifdef XOODYAK_SEQ_VERIFY_EN
        job_tag_i = ~jt;
`endif
        check("busy_on_accept", TW'(busy_o), 1);
        if (jt == '1) check("jt_unused", 0, 1);
    endtask

    task automatic do_block(input int i, input logic stall);
        logic [TW-1:0] hold;
        int st0;
        bit moved;
        wait_hi("blk_in_ready", 1);
        blk_in_valid_i = 1'b1;
        blk_in_i = in_arr[i];
        @(negedge clk);
        blk_in_valid_i = 1'b0;
        blk_in_i = {6{$urandom()}};
        wait_hi("blk_out_valid", 2);
        if (stall) begin
            hold = blk_out_o; st0 = nstart; moved = 0;
            repeat (20) begin
                @(negedge clk);
                if (blk_out_o !== hold || !blk_out_valid_o) moved = 1;
            end
            check("stall_starts", TW'(nstart - st0), 0);
            check("stall_stable", TW'(moved), 0);
        end
        out_arr[i] = blk_out_o;
        if (exp_blk.size() == 0) check("blkq_empty", 0, 1);
        else check($sformatf("blk_out%0d", i), blk_out_o, exp_blk.pop_front());
        blk_out_ready_i = 1'b1;
        @(negedge clk);
        blk_out_ready_i = 1'b0;
    endtask

    task automatic run_job(input logic dec, input int nblk, input logic [KW-1:0] k, n,
                           input logic [AW-1:0] a, input logic [KW-1:0] jt, input logic stall,
                           input logic exp_ok);
        int s0, r0;
        model(dec, nblk, k, n, a);
        s0 = nstart; r0 = nrdy;
        accept_job(dec, nblk, k, n, a, jt);
        for (int i = 0; i < nblk; i++) do_block(i, stall && i == 1);
        wait_hi("tag_valid", 3);
        tag_out = tag_o;
        if (exp_tag.size() == 0) check("tagq_empty", 0, 1);
        else check("tag", TW'(tag_o), TW'(exp_tag.pop_front()));
`ifdef XOODYAK_SEQ_VERIFY_EN
        check("tag_ok", TW'(tag_ok_o), TW'(exp_ok));
`else
        if (exp_ok === 1'bx) check("exp_ok_x", 0, 1);
`endif
        tag_ready_i = 1'b1;
        @(negedge clk);
        tag_ready_i = 1'b0;
        check("job_ready_end", TW'(job_ready_o), 1);
        check("start_count", TW'(nstart - s0), TW'(nblk + 4));
        if (nblk == 0) check("no_blk_in_ready", TW'(nrdy - r0), 0);
    endtask

    initial begin
        int s0;
        reset_i = 1'b0; job_valid_i = 1'b0; job_dec_i = 1'b0; job_nblk_i = '0;
        job_key_i = '0; job_nonce_i = '0; job_ad_i = '0;
        blk_in_valid_i = 1'b0; blk_in_i = '0; blk_out_ready_i = 1'b0; tag_ready_i = 1'b0;
`ifdef XOODYAK_SEQ_VERIFY_EN
        job_tag_i = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", TW'(busy_o), 0);
        check("rst_job_ready", TW'(job_ready_o), 1);
        check("rst_start", TW'(core_start_o), 0);
        check("rst_opmode", TW'(core_opmode_o), 0);
        check("rst_valids", TW'({blk_out_valid_o, tag_valid_o, blk_in_ready_o}), 0);
        reset_i = 1'b1;
        @(negedge clk);

        K = 128'h38393a3b3c3d3e3f3031323334353637;
        N = 128'h494a4b4c4d4e4f504142434445464748;
        A = {11{32'ha5c30f1e}};
        in_arr[0] = 192'h4d4e4f50515253545d5e5f404142434445464748494a4b4c;
        run_job(1'b0, 1, K, N, A, '0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            in_arr[i] = {6{$urandom()}} ^ {TW/32{32'h1234567 * (i + 1)}};
            pt_arr[i] = in_arr[i];
        end
        A[40:9] = $urandom();
        run_job(1'b0, 3, K ^ 128'h5, N, A, '0, 1'b0, 1'b1);
        tag_enc = tag_out;
        for (int i = 0; i < 3; i++) in_arr[i] = out_arr[i];
        run_job(1'b1, 3, K ^ 128'h5, N, A, tag_enc, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) check($sformatf("recovered%0d", i), out_arr[i], pt_arr[i]);
        check("dec_tag_eq_enc", TW'(tag_out), TW'(tag_enc));
        run_job(1'b1, 3, K ^ 128'h5, N, A, tag_enc ^ 128'h1, 1'b0, 1'b0);

        run_job(1'b0, 0, K, N ^ 128'h77, A, '0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) in_arr[i] = {6{$urandom()}};
        run_job(1'b0, 3, K, N, A ^ {AW{1'b1}}, '0, 1'b1, 1'b1);

        s0 = nstart;
        spur_req++;
        repeat (4) @(negedge clk);
        check("spur_busy", TW'(busy_o), 0);
        check("spur_start", TW'(nstart - s0), 0);

        for (int i = 0; i < 3; i++) in_arr[i] = {6{$urandom()}};
        model(1'b0, 3, K, N, A);
        accept_job(1'b0, 3, K, N, A, '0);
        do_block(0, 1'b0);
        wait_hi("blk_in_ready2", 1);
        blk_in_valid_i = 1'b1; blk_in_i = in_arr[1];
        @(negedge clk);
        blk_in_valid_i = 1'b0;
        wait_hi("crypt2_start", 4);
        abort = 1;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", TW'(busy_o), 0);
        check("abort_job_ready", TW'(job_ready_o), 1);
        check("abort_valids", TW'({blk_out_valid_o, tag_valid_o, blk_in_ready_o}), 0);
        check("abort_start_op", TW'({core_start_o, core_opmode_o}), 0);
        check("abort_key", TW'(core_key_o), 0);
        @(negedge clk);
        reset_i = 1'b1;
        s0 = nstart;
        repeat (6) @(negedge clk);
        check("abort_no_start", TW'(nstart - s0), 0);
        exp_op.delete(); exp_blk.delete(); exp_tag.delete();
        abort = 0;

        for (int i = 0; i < 2; i++) in_arr[i] = {6{$urandom()}};
        run_job(1'b0, 2, ~K, N, A, '0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
